// File: rtl/inv_pkg.sv
// ---------------------------------------------------------------------------
// inv_pkg -- shared definitions for the matrix-inversion sequencer.
//
// Contents:
//   N_DEFAULT / RW_DEFAULT  default matrix order and row-index width
//   op_e                    row-operation command encodings (cmd_op)
//   state_e                 sequencer FSM states
// ---------------------------------------------------------------------------
package inv_pkg;

    localparam int N_DEFAULT  = 5;
    localparam int RW_DEFAULT = 3;

    typedef enum logic [1:0] {
        OP_NORM = 2'd0,   // row prow /= A[prow][p]
        OP_ELIM = 2'd1,   // row trow -= A[trow][p] * row prow
        OP_SWAP = 2'd2    // exchange rows prow and trow
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        PIV_RD,
        PIV_CHK,
        SWAP,
        NORM,
        ELIM,
        FIN
    } state_e;

endpackage

// File: rtl/inv_cmd_reg.sv
// ---------------------------------------------------------------------------
// inv_cmd_reg -- valid/ready holding register for row-operation commands.
//
// A command written with load is presented on cmd_* and held unchanged
// until the downstream unit accepts it (cmd_valid && cmd_ready). A load in
// the same cycle as an acceptance replaces the command directly, so
// back-to-back commands issue with no idle cycle in between.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   load       in   write ld_* into the register (only when slot is free)
//   ld_op      in   command opcode to load
//   ld_prow    in   pivot row to load
//   ld_trow    in   target row to load
//   cmd_valid  out  command valid
//   cmd_ready  in   downstream accepts the command
//   cmd_op     out  command opcode
//   cmd_prow   out  pivot row
//   cmd_trow   out  target row
//   accepted   out  command handed over this cycle
// ---------------------------------------------------------------------------
module inv_cmd_reg
    import inv_pkg::*;
#(
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [1:0]    ld_op,
    input  logic [RW-1:0] ld_prow,
    input  logic [RW-1:0] ld_trow,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_op,
    output logic [RW-1:0] cmd_prow,
    output logic [RW-1:0] cmd_trow,
    output logic          accepted
);

    assign accepted = cmd_valid && cmd_ready;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order. The payload fields are
    // reset as well because they are visible outputs with defined reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NORM;
            cmd_prow  <= '0;
            cmd_trow  <= '0;
        end else if (load) begin
            cmd_valid <= 1'b1;
            cmd_op    <= ld_op;
            cmd_prow  <= ld_prow;
            cmd_trow  <= ld_trow;
        end else if (accepted) begin
            cmd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// inv_seq_ctrl -- Gauss-Jordan inversion sequencer.
//
// Walks pivot columns p = 0..N-1 of an N x 2N augmented matrix held in an
// external datapath. Per pivot: read A[p][p] (piv_rd/piv_zero), normalise
// the pivot row, then eliminate column p from every other row in ascending
// order. A zero pivot ends the run with singular=1, unless partial-pivot
// search is compiled in.
//
// Build option:
//   INV_PIVOT_SWAP_EN  when defined, a zero pivot probes rows p+1..N-1 and
//                      swaps the first nonzero one into place before NORM.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle run request (accepted only in IDLE)
//   busy       out  run in progress
//   done       out  one-cycle end-of-run pulse
//   singular   out  matrix found singular; valid with done, held until start
//   piv_rd     out  one-cycle pivot-read strobe
//   piv_row    out  row whose column-p element is read
//   piv_zero   in   read element below epsilon, one cycle after piv_rd
//   cmd_valid  out  row-op command valid
//   cmd_ready  in   row-op unit accepts the command
//   cmd_op     out  0 NORM, 1 ELIM, 2 SWAP
//   cmd_prow   out  pivot row
//   cmd_trow   out  target row
// ---------------------------------------------------------------------------
module inv_seq_ctrl
    import inv_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          singular,
    output logic          piv_rd,
    output logic [RW-1:0] piv_row,
    input  logic          piv_zero,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_op,
    output logic [RW-1:0] cmd_prow,
    output logic [RW-1:0] cmd_trow
);

    localparam logic [RW-1:0] LAST   = RW'(N - 1);
    localparam logic [RW-1:0] PENULT = RW'(N - 2);

    state_e        state;
    logic [RW-1:0] p;        // current pivot column / row
    logic [RW-1:0] r;        // current elimination target row
    logic [RW-1:0] q;        // row being probed for a usable pivot

    logic          accepted;
    logic          load;
    op_e           ld_op;
    logic [RW-1:0] ld_prow;
    logic [RW-1:0] ld_trow;

    logic          p_last;
    logic          elim_last;
    logic [RW-1:0] r_first;
    logic [RW-1:0] r_next;

    // Row stepping skips r == p. The final target row is N-1, or N-2 when
    // the pivot itself is N-1, so neither counter ever steps past N-1.
    assign p_last    = (p == LAST);
    assign elim_last = (r == LAST) || ((r == PENULT) && p_last);
    assign r_first   = (p == '0) ? RW'(1) : '0;
    assign r_next    = ((r + RW'(1)) == p) ? (r + RW'(2)) : (r + RW'(1));

    // Next command to place in the holding register. A load happens only
    // when the register is empty (PIV_CHK) or is handing over its current
    // command this cycle, which gives zero-bubble issue.
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        load    = 1'b0;
        ld_op   = OP_NORM;
        ld_prow = p;
        ld_trow = p;
        case (state)
            PIV_CHK: begin
                if (!piv_zero) begin
                    load = 1'b1;
`ifdef INV_PIVOT_SWAP_EN
                    if (q != p) begin
                        ld_op   = OP_SWAP;
                        ld_trow = q;
                    end
`endif
                end
            end
            SWAP: begin
                load = accepted;
            end
            NORM: begin
                load    = accepted;
                ld_op   = OP_ELIM;
                ld_trow = r_first;
            end
            ELIM: begin
                load    = accepted && !elim_last;
                ld_op   = OP_ELIM;
                ld_trow = r_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            p        <= '0;
            r        <= '0;
            q        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            singular <= 1'b0;
            piv_rd   <= 1'b0;
            piv_row  <= '0;
        end else begin
            done   <= 1'b0;
            piv_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p        <= '0;
                        q        <= '0;
                        r        <= '0;
                        singular <= 1'b0;
                        busy     <= 1'b1;
                        piv_rd   <= 1'b1;
                        piv_row  <= '0;
                        state    <= PIV_RD;
                    end
                end
                PIV_RD: begin
                    state <= PIV_CHK;
                end
                PIV_CHK: begin
                    if (!piv_zero) begin
`ifdef INV_PIVOT_SWAP_EN
                        state <= (q != p) ? SWAP : NORM;
`else
                        state <= NORM;
`endif
                    end else begin
`ifdef INV_PIVOT_SWAP_EN
                        if (q != LAST) begin
                            q       <= q + RW'(1);
                            piv_row <= q + RW'(1);
                            piv_rd  <= 1'b1;
                            state   <= PIV_RD;
                        end else begin
                            singular <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FIN;
                        end
`else
                        singular <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= FIN;
`endif
                    end
                end
                SWAP: begin
                    if (accepted) state <= NORM;
                end
                NORM: begin
                    if (accepted) begin
                        r     <= r_first;
                        state <= ELIM;
                    end
                end
                ELIM: begin
                    if (accepted) begin
                        if (!elim_last) begin
                            r <= r_next;
                        end else if (!p_last) begin
                            p       <= p + RW'(1);
                            q       <= p + RW'(1);
                            r       <= '0;
                            piv_rd  <= 1'b1;
                            piv_row <= p + RW'(1);
                            state   <= PIV_RD;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    inv_cmd_reg #(.RW(RW)) u_cmd_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .ld_op     (ld_op),
        .ld_prow   (ld_prow),
        .ld_trow   (ld_trow),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_prow  (cmd_prow),
        .cmd_trow  (cmd_trow),
        .accepted  (accepted)
    );

endmodule
